icache_assoc: RTL

Parametrised set-associative instruction cache with line refill, successor to the single-word direct-mapped instruction cache in the fetch path. It answers fetch lookups combinationally. On a miss it runs its own refill state machine that pulls a whole line from the memory controller word by word. It supports 1- or 2-way associativity with per-set LRU replacement and a single-cycle global flush for `fence.i` and branch-recovery use.

---
 rtl/icache_assoc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways) with
// multi-word line refill and per-set LRU replacement.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rdy               global enable; when low every register holds
//   flush             invalidate every line and abort any refill
//   fetch_valid/addr  lookup request (byte address, bits [1:0] ignored)
//   fetch_hit/inst    combinational lookup result (inst is 0 on a miss)
//   busy              refill in progress
//   mem_req/addr      line refill request and line base address
//   mem_word_valid    memory presents the next word (ascending offsets)
//   mem_word          refill data word
//   mem_word_ready    word is accepted this cycle
module icache_assoc #(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_hit,
  output logic [31:0] fetch_inst,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_word_valid,
  input  logic [31:0] mem_word,
  output logic        mem_word_ready
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int DA_W  = IDX_W + OFF_W;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << (OFF_W + 2)) - 32'd1);

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WAYS-1:0][SETS-1:0] r_valid;
  logic [SETS-1:0]         r_lru;      // per set: the way to evict next
  logic [31:0]             r_mem_addr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_victim;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic [DA_W-1:0]  w_rd_addr;
  logic [DA_W-1:0]  w_wr_addr;
  logic [WAYS-1:0]  w_way_hit;
  logic [31:0]      w_way_word [WAYS];
  logic             w_hit_way;
  logic             w_victim_sel;
  logic             w_last;
  logic             w_accept;
  logic             w_miss_start;
  logic [1:0]       w_unused_bits;

  assign w_idx      = fetch_addr[2+OFF_W +: IDX_W];
  assign w_tag      = fetch_addr[31 -: TAG_W];
  assign w_fill_idx = r_mem_addr[2+OFF_W +: IDX_W];
  assign w_fill_tag = r_mem_addr[31 -: TAG_W];
  // Index sits directly above the offset, so {idx, off} is one contiguous slice.
  assign w_rd_addr  = fetch_addr[2 +: DA_W];
  // Offset bits of the latched line base are zero, so OR-ing in the counter
  // forms {idx, counter} for any LINE_WORDS including 1.
  assign w_wr_addr  = r_mem_addr[2 +: DA_W] | DA_W'(r_cnt);
  assign w_unused_bits = fetch_addr[1:0];

  assign w_last       = (r_cnt == CNT_W'(LINE_WORDS - 1));
  assign w_accept     = mem_word_ready & mem_word_valid & ~rst;
  assign w_miss_start = rdy & ~flush & fetch_valid & ~fetch_hit & (r_state == S_IDLE);

  // Per-way storage; data and tags carry no reset so they map onto RAM.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [31:0]      r_data [SETS*LINE_WORDS];
      logic [TAG_W-1:0] r_tag  [SETS];

      always_ff @(posedge clk) begin
        if (w_accept && (r_victim == 1'(gi))) begin
          r_data[w_wr_addr] <= mem_word;
          if (w_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
          end
        end
      end

      assign w_way_hit[gi]  = r_valid[gi][w_idx] && (r_tag[w_idx] == w_tag);
      assign w_way_word[gi] = r_data[w_rd_addr];
    end
  endgenerate

  assign fetch_hit = fetch_valid & (|w_way_hit);
  assign w_hit_way = (WAYS == 2) ? w_way_hit[WAYS-1] : 1'b0;

  always_comb begin
    fetch_inst = 32'd0;
    for (int i = 0; i < WAYS; i++) begin
      if (fetch_hit && w_way_hit[i]) begin
        fetch_inst = w_way_word[i];
      end
    end
  end

  // Victim: first invalid way (way 0 first), otherwise the LRU way.
  generate
    if (WAYS == 2) begin : g_victim2
      always_comb begin
        if (!r_valid[0][w_idx])      w_victim_sel = 1'b0;
        else if (!r_valid[1][w_idx]) w_victim_sel = 1'b1;
        else                         w_victim_sel = r_lru[w_idx];
      end
    end else begin : g_victim1
      assign w_victim_sel = 1'b0;
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst)      r_state <= S_IDLE;
    else if (rdy) r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_miss_start) w_state_next = S_REFILL;
      S_REFILL: if (flush || (mem_word_valid && w_last)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy           = (r_state == S_REFILL);
    mem_req        = busy;
    mem_word_ready = busy & rdy & ~flush;
    mem_addr       = r_mem_addr;
  end

  // Valid/LRU bookkeeping and refill bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_lru      <= '0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_victim   <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        r_valid <= '0;
        r_lru   <= '0;
      end else begin
        if (fetch_hit && (WAYS == 2)) begin
          r_lru[w_idx] <= ~w_hit_way;
        end
        if (w_miss_start) begin
          r_mem_addr <= fetch_addr & LINE_MASK;
          r_cnt      <= '0;
          r_victim   <= w_victim_sel;
          r_valid[w_victim_sel][w_idx] <= 1'b0;
        end
        if (w_accept) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_valid[r_victim][w_fill_idx] <= 1'b1;
            // Written after the hit update so a same-set refill completion wins.
            if (WAYS == 2) begin
              r_lru[w_fill_idx] <= ~r_victim;
            end
          end
        end
      end
    end
  end

endmodule
